// File: rtl/f_loader.sv
// F-memory loader: reduces signed coefficients into [0,Q) and writes them to addresses 0..P-1.
// Optional macro F_LOADER_ZERO_PAD_EN adds a PAD state that zero-fills addresses P..PAD_LEN-1.
module f_loader #(
  parameter int RAM_WIDTH     = 13,
  parameter int RAM_ADDR_BITS = 11,
  parameter int P             = 757,
  parameter int Q             = 5167,
  parameter int PAD_LEN       = 768
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic signed [RAM_WIDTH:0]   in_coef,
  output logic                        in_ready,
  output logic                        write_enable,
  output logic [RAM_ADDR_BITS-1:0]    write_address,
  output logic [RAM_WIDTH-1:0]        input_data,
  output logic                        busy,
  output logic                        done,
  output logic                        range_err
);

  // One spare bit so the counter can represent PAD_LEN == 2**RAM_ADDR_BITS.
  localparam int CNT_W = RAM_ADDR_BITS + 1;
  localparam logic [CNT_W-1:0] LAST_COEF = CNT_W'(P - 1);

`ifdef F_LOADER_ZERO_PAD_EN
  localparam logic [CNT_W-1:0] LAST_PAD = CNT_W'(PAD_LEN - 1);
  localparam bit HAS_PAD = (PAD_LEN > P);
  typedef enum logic [1:0] {IDLE, LOAD, PAD, FIN} state_e;
`else
  typedef enum logic [1:0] {IDLE, LOAD, FIN} state_e;
`endif

  generate
    if (Q <= 0 || Q >= 2**RAM_WIDTH || P < 1 || P > PAD_LEN ||
        PAD_LEN > 2**RAM_ADDR_BITS) begin : g_bad_cfg
      $error("f_loader: invalid parameter set");
    end
  endgenerate

  // Returns {out_of_range, reduced value}; out-of-range inputs map to 0.
  function automatic logic [RAM_WIDTH:0] reduce_coef(input logic signed [RAM_WIDTH:0] c);
    logic signed [RAM_WIDTH+1:0] cx;
    logic signed [RAM_WIDTH+1:0] qx;
    logic signed [RAM_WIDTH+1:0] sum;
    cx  = {c[RAM_WIDTH], c};
    qx  = (RAM_WIDTH+2)'(Q);
    sum = cx + qx;
    if (!cx[RAM_WIDTH+1]) begin
      if (cx < qx) return {1'b0, cx[RAM_WIDTH-1:0]};
    end else if (!sum[RAM_WIDTH+1] && (sum != '0)) begin
      return {1'b0, sum[RAM_WIDTH-1:0]};
    end
    return {1'b1, {RAM_WIDTH{1'b0}}};
  endfunction

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       we_q, we_d;
  logic [RAM_ADDR_BITS-1:0]   addr_q, addr_d;
  logic [RAM_WIDTH-1:0]       data_q, data_d;
  logic                       err_q, err_d;
  logic [RAM_WIDTH:0]         red;

  assign red = reduce_coef(in_coef);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        if (in_valid && (cnt_q == LAST_COEF)) begin
`ifdef F_LOADER_ZERO_PAD_EN
          state_d = HAS_PAD ? PAD : FIN;
`else
          state_d = FIN;
`endif
        end
      end
`ifdef F_LOADER_ZERO_PAD_EN
      PAD:  if (cnt_q == LAST_PAD) state_d = FIN;
`endif
      // FIN waits while the final registered write is still on the bus.
      FIN:  if (!we_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    err_d  = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = '0;
          err_d = 1'b0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          we_d   = 1'b1;
          addr_d = cnt_q[RAM_ADDR_BITS-1:0];
          data_d = red[RAM_WIDTH-1:0];
          err_d  = err_q | red[RAM_WIDTH];
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
`ifdef F_LOADER_ZERO_PAD_EN
      PAD: begin
        we_d   = 1'b1;
        addr_d = cnt_q[RAM_ADDR_BITS-1:0];
        data_d = '0;
        cnt_d  = cnt_q + CNT_W'(1);
      end
`endif
      default: ;
    endcase
  end

  assign in_ready      = (state_q == LOAD);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN) && !we_q;
  assign write_enable  = we_q;
  assign write_address = addr_q;
  assign input_data    = data_q;
  assign range_err     = err_q;

endmodule

// File: tb/tb_f_loader.sv
// Directed bench for f_loader: table-driven reduction vectors plus full-load, stall and reset sequences.
module tb_f_loader;
  localparam int RW    = 13;
  localparam int AB    = 11;
  localparam int P     = 757;
  localparam int Q     = 5167;
  localparam int PADL  = 768;
  localparam int NADDR = 2**AB;
`ifdef F_LOADER_ZERO_PAD_EN
  localparam int EXP_LAST = PADL;
`else
  localparam int EXP_LAST = P;
`endif

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 in_valid;
  logic signed [RW:0]   in_coef;
  logic                 in_ready;
  logic                 write_enable;
  logic [AB-1:0]        write_address;
  logic [RW-1:0]        input_data;
  logic                 busy;
  logic                 done;
  logic                 range_err;

  f_loader #(.RAM_WIDTH(RW), .RAM_ADDR_BITS(AB), .P(P), .Q(Q), .PAD_LEN(PADL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_coef(in_coef),
    .in_ready(in_ready), .write_enable(write_enable), .write_address(write_address),
    .input_data(input_data), .busy(busy), .done(done), .range_err(range_err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int clr_gen = 1;

  int mem[NADDR];
  int wr_cnt[NADDR];
  int wcyc[NADDR];
  int nwr, ndone, done_cyc, last_wcyc, order_bad, prev_addr;

  int cf[P];
  int expd[NADDR];

  typedef struct {
    int grp;
    int idx;
    int coef;
    int exp_data;
  } vec_t;
  vec_t vt[11];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Write/done scoreboard, sampled on the falling edge.
  initial begin
    int seen_gen;
    int a;
    seen_gen = 0;
    forever begin
      @(negedge clk);
      if (seen_gen != clr_gen) begin
        seen_gen = clr_gen;
        for (int i = 0; i < NADDR; i++) begin
          mem[i] = -1;
          wr_cnt[i] = 0;
          wcyc[i] = -1;
        end
        nwr = 0; ndone = 0; done_cyc = -1; last_wcyc = -1; order_bad = 0; prev_addr = -1;
      end
      if (write_enable) begin
        a = int'(write_address);
        mem[a] = int'(input_data);
        wr_cnt[a]++;
        wcyc[a] = cyc;
        nwr++;
        last_wcyc = cyc;
        if (a != prev_addr + 1) order_bad++;
        prev_addr = a;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic clear_sb();
    clr_gen++;
    @(negedge clk);
    #1;
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int limit, input bit toggle, input int inj);
    int k;
    int guard;
    bit rdy;
    k = 0;
    guard = 0;
    while (k < limit && guard < 20000) begin
      guard++;
      start = (k == inj);
      if (toggle && guard[0]) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_coef  = (RW+1)'(cf[k]);
      end
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) k++;
      #1;
    end
    start = 1'b0;
    chk("feed_budget", k, limit);
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 200 && ndone == 0; i++) @(posedge clk);
    chk({nm, "_done_seen"}, (ndone != 0), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic verify(input string nm, input bit toggle);
    int bad;
    int cbad;
    int lo;
    wait_done(nm);
    bad = 0;
    for (int a = 0; a < NADDR; a++) begin
      if (a < EXP_LAST) begin
        if (wr_cnt[a] != 1 || mem[a] != expd[a]) bad++;
      end else if (wr_cnt[a] != 0) begin
        bad++;
      end
    end
    chk({nm, "_contents"}, bad, 0);
    chk({nm, "_writes"}, nwr, EXP_LAST);
    chk({nm, "_order"}, order_bad, 0);
    chk({nm, "_done_count"}, ndone, 1);
    chk({nm, "_done_cycle"}, done_cyc, last_wcyc + 1);
    chk({nm, "_busy_idle"}, busy, 0);
    lo = toggle ? P : 1;
    cbad = 0;
    for (int a = lo; a < EXP_LAST; a++) if (wcyc[a] != wcyc[a-1] + 1) cbad++;
    chk({nm, "_consecutive"}, cbad, 0);
  endtask

  task automatic plain_image();
    for (int a = 0; a < NADDR; a++) expd[a] = (a < P) ? a : 0;
    for (int a = 0; a < P; a++) cf[a] = a;
  endtask

  initial begin
    int n0;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_coef = '0;

    vt[0]  = '{0, 0, -1, 5166};
    vt[1]  = '{0, 1, -5166, 1};
    vt[2]  = '{0, 2, 5166, 5166};
    vt[3]  = '{0, 3, 0, 0};
    vt[4]  = '{0, 4, -2, 5165};
    vt[5]  = '{0, 5, 1, 1};
    vt[6]  = '{1, 10, 5167, 0};
    vt[7]  = '{1, 11, -5167, 0};
    vt[8]  = '{1, 12, 8191, 0};
    vt[9]  = '{1, 13, -8192, 0};
    vt[10] = '{1, 14, -5166, 1};

    // Reset values
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we", write_enable, 0);
    chk("rst_addr", write_address, 0);
    chk("rst_data", input_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_range_err", range_err, 0);
    #11 rst_n = 1'b1;

    // Idle without start: nothing happens even with in_valid high
    clear_sb();
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_no_write", nwr, 0);
    chk("idle_not_busy", busy, 0);
    chk("idle_not_ready", in_ready, 0);
    in_valid = 1'b0;

    // Full ascending load
    plain_image();
    clear_sb();
    do_start();
    chk("load_busy", busy, 1);
    feed(P, 1'b0, -1);
    chk("load_ready_low_after_last", in_ready, 0);
    in_valid = 1'b0;
    verify("seq", 1'b0);
    chk("seq_range_err", range_err, 0);

    // Table vectors: group 0 in range, group 1 out of range
    for (int g = 0; g < 2; g++) begin
      plain_image();
      for (int i = 0; i < 11; i++) begin
        if (vt[i].grp == g) begin
          cf[vt[i].idx] = vt[i].coef;
          expd[vt[i].idx] = vt[i].exp_data;
        end
      end
      clear_sb();
      do_start();
      feed(P, 1'b0, -1);
      in_valid = 1'b0;
      verify((g == 0) ? "tbl_in" : "tbl_out", 1'b0);
      for (int i = 0; i < 11; i++) begin
        if (vt[i].grp == g) chk($sformatf("vec_coef_%0d", vt[i].coef), mem[vt[i].idx], vt[i].exp_data);
      end
      chk((g == 0) ? "tbl_in_range_err" : "tbl_out_range_err", range_err, g);
    end

    // range_err sticky in IDLE, cleared by start; stalled load
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky_idle", range_err, 1);
    plain_image();
    clear_sb();
    do_start();
    chk("err_cleared_by_start", range_err, 0);
    feed(P, 1'b1, -1);
    in_valid = 1'b0;
    verify("stall", 1'b1);

    // Reset in the middle of a load
    plain_image();
    clear_sb();
    do_start();
    feed(300, 1'b0, -1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_we", write_enable, 0);
    chk("midrst_addr", write_address, 0);
    chk("midrst_data", input_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", in_ready, 0);
    n0 = nwr;
    repeat (2) @(posedge clk);
    #7 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("postrst_no_write", nwr, n0);
    chk("postrst_idle", busy, 0);
    in_valid = 1'b0;

    // Restart after reset, with a start pulse injected mid-load
    plain_image();
    clear_sb();
    do_start();
    feed(P, 1'b0, 50);
    in_valid = 1'b0;
    verify("restart", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
